// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_32_seq_sub_33.sv
// Combinational trial subtractor: diff = a + ~b + 1, borrow = no carry out.
// Full 4-bit groups use a lookahead carry chain; a trailing partial group ripples.
module sub_33
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_WIDTH + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int unsigned NB = (W + 3) / 4;

  logic [W-1:0]  nb;
  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [NB-1:0] bc;
  logic          cin;

  assign nb = ~b;
  assign g  = a & nb;
  assign p  = a ^ nb;

  always_comb begin
    bc    = '0;
    bc[0] = 1'b1;
    for (int unsigned k = 0; k + 1 < NB; k++) begin
      bc[k+1] = g[4*k+3]
              | (p[4*k+3] & g[4*k+2])
              | (&p[4*k+3 -: 2] & g[4*k+1])
              | (&p[4*k+3 -: 3] & g[4*k])
              | (&p[4*k +: 4] & bc[k]);
    end
  end

  always_comb begin
    diff = '0;
    cin  = 1'b0;
    for (int unsigned k = 0; k < NB; k++) begin
      cin = bc[k];
      for (int unsigned j = 0; j < 4; j++) begin
        if (4*k + j < W) begin
          diff[4*k+j] = p[4*k+j] ^ cin;
          cin         = g[4*k+j] | (p[4*k+j] & cin);
        end
      end
    end
    borrow = ~cin;
  end

endmodule

// File: rtl/div_32_seq.sv
// Sequential restoring divider: one quotient bit per clock, fixed latency.
module div_32_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] next_rem;
  logic [WIDTH-1:0] next_dq;

  // dq shifts dividend bits out of its MSB while quotient bits enter at the
  // LSB; after WIDTH steps it holds the complete quotient.
  assign shifted  = {prem, dq[WIDTH-1]};
  assign next_rem = borrow ? WIDTH'(shifted) : WIDTH'(trial);
  assign next_dq  = {dq[WIDTH-2:0], ~borrow};

  sub_33 #(.W(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (trial),
    .borrow (borrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      dvs         <= '0;
      prem        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dq    <= dividend;
            dvs   <= divisor;
            prem  <= '0;
            cnt   <= '0;
            busy  <= (divisor != '0);
            state <= CALC;
          end
        end
        CALC: begin
          if (dvs == '0) begin
            quotient    <= '1;
            remainder   <= dq;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            prem <= next_rem;
            dq   <= next_dq;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'(WIDTH - 1)) begin
              quotient    <= next_dq;
              remainder   <= next_rem;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32_seq.sv
// Self-checking bench for div_32_seq: arithmetic reference model plus directed literals.
module tb_div_32_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  div_32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  bit          chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // Reference model: cycles left until the result appears, results from / and %.
  int          m_left = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_q = '0;
  logic [31:0] m_r = '0;
  logic        m_dz = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dz   <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_a    <= dividend;
        m_b    <= divisor;
        m_left <= (divisor == 0) ? 1 : 32;
        m_busy <= (divisor != 0);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_q    <= (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
        m_r    <= (m_b == 0) ? m_a : m_a % m_b;
        m_dz   <= (m_b == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
      check("div_by_zero", div_by_zero, m_dz);
      check("busy_and_done", busy & done, 0);
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Called in the first cycle after acceptance; returns when the bench is in IDLE again.
  task automatic wait_done(output int lat, output int bcy);
    lat = 1;
    bcy = 0;
    while (!done && lat < 40) begin
      if (busy) bcy++;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                     input int exp_busy, input logic [31:0] eq, input logic [31:0] er,
                     input logic edz);
    int lat, bcy;
    launch(a, b);
    wait_done(lat, bcy);
    check("latency", lat, exp_lat);
    check("busy_cycles", bcy, exp_busy);
    check("lit_quotient", quotient, eq);
    check("lit_remainder", remainder, er);
    check("lit_div_by_zero", div_by_zero, edz);
  endtask

  initial begin
    int lat, bcy;
    logic [31:0] a, b;

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(32'd100, 32'd7, 33, 32, 32'd14, 32'd2, 1'b0);
    run(32'hFFFF_FFFF, 32'd1, 33, 32, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run(32'd3, 32'd10, 33, 32, 32'd0, 32'd3, 1'b0);
    run(32'd5, 32'd0, 2, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);

    // A start during CALC must not disturb the running division.
    launch(32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    start = 1'b1; dividend = 32'd9; divisor = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcy);
    check("ignored_start_q", quotient, 333);
    check("ignored_start_r", remainder, 1);
    run(32'd9, 32'd9, 33, 32, 32'd1, 32'd0, 1'b0);

    // Reset sampled at the tenth iteration edge aborts the division.
    launch(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_dz", div_by_zero, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", done, 0);
    run(32'd50, 32'd8, 33, 32, 32'd6, 32'd2, 1'b0);

    // Random traffic: starts in every state, operand noise, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      a = $urandom;
      case ($urandom % 8)
        0: b = 32'd0;
        1: b = 32'd1;
        2: b = $urandom % 16;
        3: b = a;
        4: b = a + 32'd1;
        default: b = $urandom >> ($urandom % 32);
      endcase
      if ($urandom % 3 == 0) a = a >> ($urandom % 32);
      dividend = a;
      divisor  = b;
      start    = ($urandom % 3 == 0);
      rst_n    = ($urandom % 400 != 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
